// File: rtl/instr_mem_sync.sv
// instr_mem_sync: clocked, writable instruction memory serving one word-aligned
// fetch at a time over a valid/ready handshake, with a fixed wait-state latency.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready fetch request handshake, req_addr = byte address
//   resp_valid/ready    response handshake, instr = fetched word,
//                       resp_err = misaligned or out-of-range fetch
//   wr_en/addr/data     program-load write port, independent of the fetch FSM
//   wr_err              one-cycle pulse for a rejected write
//   fetch_count         saturating count of completed responses
//
// Optional: define INSTR_MEM_TRACE_EN for simulation-only trace prints of
// response handshakes and rejected writes. Cycle behaviour is unchanged.
module instr_mem_sync #(
    parameter int unsigned       DATA_W      = 32,
    parameter int unsigned       ADDR_W      = 32,
    parameter int unsigned       DEPTH       = 64,
    parameter int unsigned       WAIT_CYCLES = 2,
    parameter logic [DATA_W-1:0] NOP_INSTR   = DATA_W'(32'h38800000)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] instr,
    output logic              resp_err,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_err,
    output logic [15:0]       fetch_count
);

    localparam int unsigned IDX_W  = ADDR_W - 2;
    localparam int unsigned MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [ADDR_W-1:0]   addr_q, addr_nxt;
    logic [DATA_W-1:0]   instr_nxt;
    logic                err_nxt;
    logic [15:0]         count_nxt;
    logic                load_resp;
    logic                req_ready_nxt;
    logic                resp_valid_nxt;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic [ADDR_W-1:0]   rd_addr_c;
    logic                rd_err_c;
    logic [DATA_W-1:0]   rd_word_c;
    logic                wr_bad_c;

    // Misaligned or word index beyond the array
    function automatic logic addr_bad(input logic [ADDR_W-1:0] a);
        return (a[1:0] != 2'b00) || (a[ADDR_W-1:2] >= IDX_W'(DEPTH));
    endfunction

    // With zero wait states the response is captured on the accept edge,
    // so the live request address is used in IDLE.
    assign rd_addr_c = (state == IDLE) ? req_addr : addr_q;
    assign rd_err_c  = addr_bad(rd_addr_c);
    assign rd_word_c = rd_err_c ? NOP_INSTR : mem[rd_addr_c[MEM_AW+1:2]];
    assign wr_bad_c  = addr_bad(wr_addr);

    // Next-state and registered-output logic
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        addr_nxt  = addr_q;
        instr_nxt = instr;
        err_nxt   = resp_err;
        count_nxt = fetch_count;
        load_resp = 1'b0;

        case (state)
            IDLE: begin
                if (req_valid) begin
                    addr_nxt = req_addr;
                    cnt_nxt  = CNT_W'(WAIT_CYCLES);
                    if (WAIT_CYCLES == 0) begin
                        state_nxt = RESP;
                        load_resp = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_nxt = RESP;
                    load_resp = 1'b1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_nxt = IDLE;
                    if (fetch_count != 16'hFFFF) begin
                        count_nxt = fetch_count + 16'd1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Memory is read on the edge entering RESP; a same-edge write is not seen
        if (load_resp) begin
            instr_nxt = rd_word_c;
            err_nxt   = rd_err_c;
        end

        req_ready_nxt  = (state_nxt == IDLE);
        resp_valid_nxt = (state_nxt == RESP);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            addr_q      <= '0;
            instr       <= NOP_INSTR;
            resp_err    <= 1'b0;
            fetch_count <= '0;
            req_ready   <= 1'b1;
            resp_valid  <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            addr_q      <= addr_nxt;
            instr       <= instr_nxt;
            resp_err    <= err_nxt;
            fetch_count <= count_nxt;
            req_ready   <= req_ready_nxt;
            resp_valid  <= resp_valid_nxt;
        end
    end

    // Storage array and write-reject pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= NOP_INSTR;
            end
            wr_err <= 1'b0;
        end else begin
            wr_err <= wr_en && wr_bad_c;
            if (wr_en && !wr_bad_c) begin
                mem[wr_addr[MEM_AW+1:2]] <= wr_data;
            end
        end
    end

`ifdef INSTR_MEM_TRACE_EN
    // Simulation-only trace of response handshakes and rejected writes
    always @(posedge clk) begin
        if (rst_n && resp_valid && resp_ready) begin
            $display("[%0t] instr_mem_sync resp addr=%h instr=%h err=%0b",
                     $time, addr_q, instr, resp_err);
        end
        if (rst_n && wr_en && wr_bad_c) begin
            $display("[%0t] instr_mem_sync write rejected addr=%h", $time, wr_addr);
        end
    end
`else
    // Trace disabled: no display statements compiled
`endif

endmodule

// File: tb/tb_instr_mem_sync.sv
// Bench for instr_mem_sync: two instances (2 wait states and 0 wait states)
// share reset, write port and resp_ready; each has its own request inputs.
// Expected responses are pushed to a scoreboard queue at request time.
module tb_instr_mem_sync;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DEPTH  = 64;
    localparam logic [31:0] NOP    = 32'h38800000;

    logic        clk;
    logic        rst_n;
    logic        req_valid, req_valid0;
    logic [31:0] req_addr, req_addr0;
    logic        resp_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;

    logic        req_ready, resp_valid, resp_err, wr_err;
    logic [31:0] instr;
    logic [15:0] fetch_count;
    logic        req_ready0, resp_valid0, resp_err0, wr_err0;
    logic [31:0] instr0;
    logic [15:0] fetch_count0;

    typedef struct packed {
        logic [31:0] instr;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model[DEPTH];
    int          total;
    int          bad;

    instr_mem_sync #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
                     .WAIT_CYCLES(2), .NOP_INSTR(NOP)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .instr(instr), .resp_err(resp_err),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_err(wr_err), .fetch_count(fetch_count)
    );

    instr_mem_sync #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
                     .WAIT_CYCLES(0), .NOP_INSTR(NOP)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid0), .req_ready(req_ready0), .req_addr(req_addr0),
        .resp_valid(resp_valid0), .resp_ready(resp_ready),
        .instr(instr0), .resp_err(resp_err0),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_err(wr_err0), .fetch_count(fetch_count0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic exp_t predict(input logic [31:0] a);
        exp_t e;
        if (a[1:0] != 2'b00 || (a >> 2) >= 32'(DEPTH)) begin
            e.instr = NOP;
            e.err   = 1'b1;
        end else begin
            e.instr = model[a[7:2]];
            e.err   = 1'b0;
        end
        return e;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < int'(DEPTH); i++) model[i] = NOP;
        sb.delete();
    endtask

    // One write cycle; returns #1 after the write edge
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
        if (a[1:0] == 2'b00 && (a >> 2) < 32'(DEPTH)) model[a[7:2]] = d;
    endtask

    // Present a request until accepted; returns #1 after the accept edge
    task automatic issue(input bit sel, input logic [31:0] a);
        int n = 0;
        while (!(sel ? req_ready0 : req_ready) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) begin
            total++; bad++;
            $display("FAIL issue_ready got=0 required=1");
        end
        if (sel) begin req_valid0 = 1'b1; req_addr0 = a; end
        else     begin req_valid  = 1'b1; req_addr  = a; end
        sb.push_back(predict(a));
        @(posedge clk); #1;
        req_valid  = 1'b0;
        req_valid0 = 1'b0;
    endtask

    // Wait for resp_valid (lat counts edges from the accept edge), then
    // complete the handshake if resp_ready is high
    task automatic collect(input bit sel, output logic [31:0] oi,
                           output logic oe, output int lat);
        lat = 1;
        while (!(sel ? resp_valid0 : resp_valid) && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        oi = sel ? instr0 : instr;
        oe = sel ? resp_err0 : resp_err;
        if (resp_ready) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 0; req_valid0 = 0; req_addr = 0; req_addr0 = 0;
        resp_ready = 1'b1; wr_en = 0; wr_addr = 0; wr_data = 0;
        model_clear();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        total++; if (req_ready !== 1'b1)   begin bad++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
        total++; if (resp_valid !== 1'b0)  begin bad++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
        total++; if (instr !== NOP)        begin bad++; $display("FAIL reset_instr got=%h exp=%h", instr, NOP); end
        total++; if (resp_err !== 1'b0)    begin bad++; $display("FAIL reset_resp_err got=%b exp=0", resp_err); end
        total++; if (wr_err !== 1'b0)      begin bad++; $display("FAIL reset_wr_err got=%b exp=0", wr_err); end
        total++; if (fetch_count !== 16'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", fetch_count); end
    endtask

    task automatic test_basic();
        logic [31:0] addrs[4];
        logic [31:0] oi; logic oe; int lat; exp_t e;
        addrs = '{32'd0, 32'd4, 32'd8, 32'd6};
        wr(32'd0, 32'h58000001);
        wr(32'd4, 32'h58080002);
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, addrs[i]);
            collect(1'b0, oi, oe, lat);
            e = sb.pop_front();
            total++; if (oi !== e.instr) begin bad++; $display("FAIL basic_instr[%0d] got=%h exp=%h", i, oi, e.instr); end
            total++; if (oe !== e.err)   begin bad++; $display("FAIL basic_err[%0d] got=%b exp=%b", i, oe, e.err); end
            total++; if (lat != 3)       begin bad++; $display("FAIL basic_latency[%0d] got=%0d exp=3", i, lat); end
            if (i == 1) begin
                total++; if (fetch_count !== 16'd2) begin bad++; $display("FAIL basic_count got=%0d exp=2", fetch_count); end
            end
        end
    endtask

    task automatic test_errors();
        logic [31:0] oi; logic oe; int lat; exp_t e;
        issue(1'b0, 32'd256);
        collect(1'b0, oi, oe, lat);
        e = sb.pop_front();
        total++; if (oi !== NOP || e.instr !== NOP) begin bad++; $display("FAIL range_instr got=%h exp=%h", oi, NOP); end
        total++; if (oe !== 1'b1)   begin bad++; $display("FAIL range_err got=%b exp=1", oe); end
        total++; if (lat != 3)      begin bad++; $display("FAIL range_latency got=%0d exp=3", lat); end
        total++; if (fetch_count !== 16'd5) begin bad++; $display("FAIL err_count got=%0d exp=5", fetch_count); end
    endtask

    task automatic test_stall();
        logic [31:0] oi; logic oe; int lat; exp_t e;
        wr(32'd16, 32'hA5A50010);
        wr(32'd20, 32'h5A5A0014);
        resp_ready = 1'b0;
        issue(1'b0, 32'd16);
        collect(1'b0, oi, oe, lat);
        e = sb.pop_front();
        total++; if (oi !== e.instr) begin bad++; $display("FAIL stall_instr got=%h exp=%h", oi, e.instr); end
        req_valid = 1'b1;
        req_addr  = 32'd20;
        repeat (5) begin
            @(posedge clk); #1;
            total++; if (resp_valid !== 1'b1 || instr !== e.instr || req_ready !== 1'b0) begin
                bad++;
                $display("FAIL stall_hold valid=%b instr=%h ready=%b exp valid=1 instr=%h ready=0",
                         resp_valid, instr, req_ready, e.instr);
            end
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        total++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            bad++; $display("FAIL stall_release valid=%b ready=%b exp valid=0 ready=1", resp_valid, req_ready);
        end
        total++; if (fetch_count !== 16'd6) begin bad++; $display("FAIL stall_count got=%0d exp=6", fetch_count); end
        sb.push_back(predict(32'd20));
        @(posedge clk); #1;
        req_valid = 1'b0;
        collect(1'b0, oi, oe, lat);
        e = sb.pop_front();
        total++; if (oi !== e.instr) begin bad++; $display("FAIL pending_instr got=%h exp=%h", oi, e.instr); end
        total++; if (lat != 3)       begin bad++; $display("FAIL pending_latency got=%0d exp=3", lat); end
    endtask

    task automatic test_collision();
        logic [31:0] oi; logic oe; int lat; exp_t e;
        wr(32'd12, 32'h11110003);
        issue(1'b0, 32'd12);
        @(posedge clk); #1;
        wr_en = 1'b1; wr_addr = 32'd12; wr_data = 32'h22220003;
        @(posedge clk); #1;
        wr_en = 1'b0;
        model[3] = 32'h22220003;
        collect(1'b0, oi, oe, lat);
        e = sb.pop_front();
        total++; if (oi !== e.instr || oi !== 32'h11110003) begin bad++; $display("FAIL collide_old got=%h exp=%h", oi, 32'h11110003); end
        issue(1'b0, 32'd12);
        collect(1'b0, oi, oe, lat);
        e = sb.pop_front();
        total++; if (oi !== e.instr) begin bad++; $display("FAIL collide_new got=%h exp=%h", oi, e.instr); end
        wr(32'd3, 32'hDEADBEEF);
        total++; if (wr_err !== 1'b1) begin bad++; $display("FAIL wr_err_pulse got=%b exp=1", wr_err); end
        @(posedge clk); #1;
        total++; if (wr_err !== 1'b0) begin bad++; $display("FAIL wr_err_clear got=%b exp=0", wr_err); end
        wr(32'd256, 32'hDEADBEEF);
        total++; if (wr_err !== 1'b1) begin bad++; $display("FAIL wr_err_range got=%b exp=1", wr_err); end
        issue(1'b0, 32'd0);
        collect(1'b0, oi, oe, lat);
        e = sb.pop_front();
        total++; if (oi !== e.instr) begin bad++; $display("FAIL wr_reject_mem got=%h exp=%h", oi, e.instr); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] oi; logic oe; int lat; exp_t e;
        issue(1'b0, 32'd0);
        rst_n = 1'b0;
        #1;
        model_clear();
        total++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            bad++; $display("FAIL midreset valid=%b ready=%b exp valid=0 ready=1", resp_valid, req_ready);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL midreset_noresp got=%b exp=0", resp_valid); end
        issue(1'b0, 32'd0);
        collect(1'b0, oi, oe, lat);
        e = sb.pop_front();
        total++; if (oi !== e.instr || oi !== NOP) begin bad++; $display("FAIL midreset_mem got=%h exp=%h", oi, NOP); end
        total++; if (fetch_count !== 16'd1) begin bad++; $display("FAIL midreset_count got=%0d exp=1", fetch_count); end
    endtask

    task automatic test_wait0();
        logic [31:0] oi; logic oe; int lat; exp_t e;
        wr(32'd0, 32'h77770000);
        issue(1'b1, 32'd0);
        collect(1'b1, oi, oe, lat);
        e = sb.pop_front();
        total++; if (oi !== e.instr) begin bad++; $display("FAIL w0_instr got=%h exp=%h", oi, e.instr); end
        total++; if (lat != 1)       begin bad++; $display("FAIL w0_latency got=%0d exp=1", lat); end
        issue(1'b1, 32'd6);
        collect(1'b1, oi, oe, lat);
        e = sb.pop_front();
        total++; if (oi !== e.instr || oe !== e.err) begin bad++; $display("FAIL w0_err got=%h/%b exp=%h/%b", oi, oe, e.instr, e.err); end
        total++; if (fetch_count0 !== 16'd2) begin bad++; $display("FAIL w0_count got=%0d exp=2", fetch_count0); end
        resp_ready = 1'b0;
        issue(1'b1, 32'd0);
        rst_n = 1'b0;
        #1;
        model_clear();
        total++; if (resp_valid0 !== 1'b0 || req_ready0 !== 1'b1) begin
            bad++; $display("FAIL w0_midreset valid=%b ready=%b exp valid=0 ready=1", resp_valid0, req_ready0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        resp_ready = 1'b1;
        issue(1'b1, 32'd0);
        collect(1'b1, oi, oe, lat);
        e = sb.pop_front();
        total++; if (oi !== e.instr || oi !== NOP || lat != 1) begin
            bad++; $display("FAIL w0_after_reset got=%h lat=%0d exp=%h lat=1", oi, lat, NOP);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_basic();
        test_errors();
        test_stall();
        test_collision();
        test_reset_mid();
        test_wait0();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
